// File: rtl/cci_mpf_test_multibeat_responder_pkg.sv
// Shared types for the multi-beat CCI test responder: beat/length types,
// FIFO entry layouts and the write packet assembler state encoding.
package cci_mpf_test_mbr_pkg;

  localparam int MBR_ADDR_WIDTH  = 42;
  localparam int MBR_MDATA_WIDTH = 16;

  typedef logic [1:0] t_cci_clLen;
  typedef logic [1:0] t_cci_clNum;

  // One queued read request: line address of beat 0, beats-1, tag.
  typedef struct packed {
    logic [MBR_ADDR_WIDTH-1:0]  addr;
    t_cci_clLen                 len;
    logic [MBR_MDATA_WIDTH-1:0] mdata;
  } t_mbr_rd_entry;

  // One completed write packet awaiting its response(s).
  typedef struct packed {
    t_cci_clLen                 len;
    logic [MBR_MDATA_WIDTH-1:0] mdata;
  } t_mbr_wr_entry;

  // Write packet assembler: IDLE = no packet open, OPEN = waiting for flits.
  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_OPEN = 1'b1
  } t_mbr_wr_state;

  // Beat index presented on the bus for the beat-th emitted flit.
  function automatic t_cci_clNum mbr_beat_num(t_cci_clNum beat, t_cci_clLen len,
                                              logic reverse);
    return reverse ? t_cci_clNum'(len - beat) : beat;
  endfunction

endpackage

// File: rtl/cci_mpf_test_multibeat_responder_if.sv
// Request/response bundle between a CCI request source and the responder.
//
// Handshake: every *_en / *_valid is a single-cycle qualifier with no ready.
// A request flit counts in exactly the cycle its en is high (the responder
// drops it and flags err_overflow if the FIFO is full); a response flit is
// delivered in exactly the cycle its valid is high and cannot be stalled.
interface cci_mpf_test_multibeat_responder_if
  import cci_mpf_test_mbr_pkg::*;
#(
  parameter int MDATA_WIDTH = 16,
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512
);
  logic                   rd_req_en;
  logic [ADDR_WIDTH-1:0]  rd_req_addr;
  t_cci_clLen             rd_req_len;
  logic [MDATA_WIDTH-1:0] rd_req_mdata;
  logic                   wr_req_en;
  logic                   wr_req_sop;
  t_cci_clLen             wr_req_len;
  logic [MDATA_WIDTH-1:0] wr_req_mdata;
  logic                   c0_alm_full;
  logic                   c1_alm_full;
  logic                   c0_rsp_valid;
  logic [MDATA_WIDTH-1:0] c0_rsp_mdata;
  t_cci_clNum             c0_rsp_cl_num;
  logic [DATA_WIDTH-1:0]  c0_rsp_data;
  logic                   c1_rsp_valid;
  logic [MDATA_WIDTH-1:0] c1_rsp_mdata;
  t_cci_clNum             c1_rsp_cl_num;
  logic                   c1_rsp_format;
  logic                   err_overflow;
  logic                   err_wr_proto;

  modport master (
    output rd_req_en, rd_req_addr, rd_req_len, rd_req_mdata,
    output wr_req_en, wr_req_sop, wr_req_len, wr_req_mdata,
    input  c0_alm_full, c1_alm_full,
    input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data,
    input  c1_rsp_valid, c1_rsp_mdata, c1_rsp_cl_num, c1_rsp_format,
    input  err_overflow, err_wr_proto
  );

  modport slave (
    input  rd_req_en, rd_req_addr, rd_req_len, rd_req_mdata,
    input  wr_req_en, wr_req_sop, wr_req_len, wr_req_mdata,
    output c0_alm_full, c1_alm_full,
    output c0_rsp_valid, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data,
    output c1_rsp_valid, c1_rsp_mdata, c1_rsp_cl_num, c1_rsp_format,
    output err_overflow, err_wr_proto
  );
endinterface

// File: rtl/cci_mpf_test_multibeat_responder_fifo.sv
// Registered request FIFO. Full/empty/almost-full are derived only from the
// registered occupancy, so a pop in the same cycle never makes room for a push.
module cci_mpf_test_mbr_fifo #(
  parameter type T              = logic,
  parameter int  DEPTH          = 16,
  parameter int  ALM_FULL_SLACK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  T     i_push_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty,
  output logic o_alm_full
);
  localparam int PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_alm_full = (r_count >= (PTR_W+1)'(DEPTH - ALM_FULL_SLACK));
  assign o_head     = r_mem[r_rd_ptr];
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally at DEPTH; occupancy holds on push+pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cci_mpf_test_multibeat_responder.sv
// FIU-side multi-beat responder: queues read requests and completed write
// packets, then streams one response flit per cycle per channel.
module cci_mpf_test_multibeat_responder
  import cci_mpf_test_mbr_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH  = 16,
  parameter int ALM_FULL_SLACK  = 4,
  parameter int MDATA_WIDTH     = MBR_MDATA_WIDTH,
  parameter int ADDR_WIDTH      = MBR_ADDR_WIDTH,
  parameter int DATA_WIDTH      = 512,
  parameter int PACK_WR_RSP     = 0,
  parameter int RD_BEAT_REVERSE = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  cci_mpf_test_multibeat_responder_if.slave bus,
  output t_mbr_wr_state                     o_dbg_wr_state
);
  localparam logic REVERSE = (RD_BEAT_REVERSE != 0);
  localparam logic PACKED  = (PACK_WR_RSP != 0);

  // ---------------- read channel ----------------
  t_mbr_rd_entry          w_rd_push_data, w_rd_head;
  logic                   w_rd_empty, w_rd_full, w_rd_alm, w_rd_pop, w_rd_last;
  t_cci_clNum             r_rd_beat, w_rd_cl_num;
  logic [ADDR_WIDTH-1:0]  w_rd_line_addr;
  logic                   r_c0_valid;
  logic [MDATA_WIDTH-1:0] r_c0_mdata;
  t_cci_clNum             r_c0_cl_num;
  logic [DATA_WIDTH-1:0]  r_c0_data;

  assign w_rd_push_data = '{addr: bus.rd_req_addr, len: bus.rd_req_len, mdata: bus.rd_req_mdata};
  assign w_rd_cl_num    = mbr_beat_num(r_rd_beat, w_rd_head.len, REVERSE);
  assign w_rd_last      = (r_rd_beat == w_rd_head.len);
  assign w_rd_pop       = !w_rd_empty && w_rd_last;
  assign w_rd_line_addr = w_rd_head.addr + ADDR_WIDTH'(w_rd_cl_num);

  cci_mpf_test_mbr_fifo #(.T(t_mbr_rd_entry), .DEPTH(REQ_FIFO_DEPTH),
                          .ALM_FULL_SLACK(ALM_FULL_SLACK)) u_rd_fifo (
    .clk(clk), .reset(reset), .i_push(bus.rd_req_en), .i_push_data(w_rd_push_data),
    .i_pop(w_rd_pop), .o_head(w_rd_head), .o_full(w_rd_full), .o_empty(w_rd_empty),
    .o_alm_full(w_rd_alm)
  );

  // Read beat counter: advances every cycle a head exists, restarts after the last beat.
  always_ff @(posedge clk) begin
    if (reset)            r_rd_beat <= '0;
    else if (!w_rd_empty) r_rd_beat <= w_rd_last ? '0 : r_rd_beat + 2'd1;
  end

  // Registered c0 response flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c0_valid  <= 1'b0;
      r_c0_mdata  <= '0;
      r_c0_cl_num <= '0;
      r_c0_data   <= '0;
    end else begin
      r_c0_valid <= !w_rd_empty;
      if (!w_rd_empty) begin
        r_c0_mdata  <= w_rd_head.mdata;
        r_c0_cl_num <= w_rd_cl_num;
        r_c0_data   <= {(DATA_WIDTH/64){64'(w_rd_line_addr)}};
      end
    end
  end

  // ---------------- write channel ----------------
  t_mbr_wr_state          r_wr_state, w_wr_state_nxt;
  t_cci_clNum             r_wr_cnt, w_wr_cnt_nxt;
  t_cci_clLen             r_wr_len, w_wr_len_nxt;
  logic [MDATA_WIDTH-1:0] r_wr_mdata, w_wr_mdata_nxt;
  logic                   w_wr_push, w_wr_proto_err;
  t_mbr_wr_entry          w_wr_push_data, w_wr_head;
  logic                   w_wr_empty, w_wr_full, w_wr_alm, w_wr_pop, w_wr_last;
  t_cci_clNum             r_wr_beat;
  logic                   r_c1_valid, r_c1_format;
  logic [MDATA_WIDTH-1:0] r_c1_mdata;
  t_cci_clNum             r_c1_cl_num;
  logic                   r_err_overflow, r_err_wr_proto;

  // Packet assembler state register and per-packet fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= WR_IDLE;
      r_wr_cnt   <= '0;
      r_wr_len   <= '0;
      r_wr_mdata <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_wr_len   <= w_wr_len_nxt;
      r_wr_mdata <= w_wr_mdata_nxt;
    end
  end

  // Packet assembler next state: a sop always restarts, completion enqueues {len,mdata}.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_len_nxt   = r_wr_len;
    w_wr_mdata_nxt = r_wr_mdata;
    w_wr_push      = 1'b0;
    w_wr_push_data = '{len: r_wr_len, mdata: r_wr_mdata};
    w_wr_proto_err = 1'b0;
    if (bus.wr_req_en) begin
      if (bus.wr_req_sop) begin
        w_wr_proto_err = (r_wr_state == WR_OPEN);
        w_wr_cnt_nxt   = '0;
        w_wr_len_nxt   = bus.wr_req_len;
        w_wr_mdata_nxt = bus.wr_req_mdata;
        if (bus.wr_req_len == 2'd0) begin
          w_wr_push      = 1'b1;
          w_wr_push_data = '{len: 2'd0, mdata: bus.wr_req_mdata};
          w_wr_state_nxt = WR_IDLE;
        end else begin
          w_wr_state_nxt = WR_OPEN;
        end
      end else if (r_wr_state == WR_IDLE) begin
        w_wr_proto_err = 1'b1;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + 2'd1;
        if (w_wr_cnt_nxt == r_wr_len) begin
          w_wr_push      = 1'b1;
          w_wr_state_nxt = WR_IDLE;
        end
      end
    end
  end

  assign w_wr_last = PACKED || (r_wr_beat == w_wr_head.len);
  assign w_wr_pop  = !w_wr_empty && w_wr_last;

  cci_mpf_test_mbr_fifo #(.T(t_mbr_wr_entry), .DEPTH(REQ_FIFO_DEPTH),
                          .ALM_FULL_SLACK(ALM_FULL_SLACK)) u_wr_fifo (
    .clk(clk), .reset(reset), .i_push(w_wr_push), .i_push_data(w_wr_push_data),
    .i_pop(w_wr_pop), .o_head(w_wr_head), .o_full(w_wr_full), .o_empty(w_wr_empty),
    .o_alm_full(w_wr_alm)
  );

  // Write response beat counter (stays 0 in packed mode).
  always_ff @(posedge clk) begin
    if (reset)            r_wr_beat <= '0;
    else if (!w_wr_empty) r_wr_beat <= w_wr_last ? '0 : r_wr_beat + 2'd1;
  end

  // Registered c1 response flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c1_valid  <= 1'b0;
      r_c1_mdata  <= '0;
      r_c1_cl_num <= '0;
      r_c1_format <= 1'b0;
    end else begin
      r_c1_valid <= !w_wr_empty;
      if (!w_wr_empty) begin
        r_c1_mdata  <= w_wr_head.mdata;
        r_c1_cl_num <= PACKED ? w_wr_head.len : r_wr_beat;
        r_c1_format <= PACKED;
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_overflow <= 1'b0;
      r_err_wr_proto <= 1'b0;
    end else begin
      r_err_overflow <= r_err_overflow | (bus.rd_req_en & w_rd_full) | (w_wr_push & w_wr_full);
      r_err_wr_proto <= r_err_wr_proto | w_wr_proto_err;
    end
  end

  assign bus.c0_alm_full   = w_rd_alm;
  assign bus.c1_alm_full   = w_wr_alm;
  assign bus.c0_rsp_valid  = r_c0_valid;
  assign bus.c0_rsp_mdata  = r_c0_mdata;
  assign bus.c0_rsp_cl_num = r_c0_cl_num;
  assign bus.c0_rsp_data   = r_c0_data;
  assign bus.c1_rsp_valid  = r_c1_valid;
  assign bus.c1_rsp_mdata  = r_c1_mdata;
  assign bus.c1_rsp_cl_num = r_c1_cl_num;
  assign bus.c1_rsp_format = r_c1_format;
  assign bus.err_overflow  = r_err_overflow;
  assign bus.err_wr_proto  = r_err_wr_proto;
  assign o_dbg_wr_state    = r_wr_state;
endmodule

// File: tb/tb_cci_mpf_test_multibeat_responder.sv
// Directed bench: instance a uses defaults, instance b uses packed write
// responses and reversed read beats; both see identical stimulus.
module tb_cci_mpf_test_multibeat_responder;
  import cci_mpf_test_mbr_pkg::*;

  localparam int MW = 16;
  localparam int AW = 42;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  t_mbr_wr_state dbg_a, dbg_b;

  typedef struct {
    int            cyc;
    logic [MW-1:0] mdata;
    logic [1:0]    cl_num;
    logic [DW-1:0] data;
    logic          fmt;
  } rsp_t;

  rsp_t c0_qa[$], c0_qb[$], c1_qa[$], c1_qb[$];
  logic [MW-1:0] exp_q[$];

  cci_mpf_test_multibeat_responder_if #(.MDATA_WIDTH(MW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  cci_mpf_test_multibeat_responder_if #(.MDATA_WIDTH(MW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  assign bus_b.rd_req_en    = bus_a.rd_req_en;
  assign bus_b.rd_req_addr  = bus_a.rd_req_addr;
  assign bus_b.rd_req_len   = bus_a.rd_req_len;
  assign bus_b.rd_req_mdata = bus_a.rd_req_mdata;
  assign bus_b.wr_req_en    = bus_a.wr_req_en;
  assign bus_b.wr_req_sop   = bus_a.wr_req_sop;
  assign bus_b.wr_req_len   = bus_a.wr_req_len;
  assign bus_b.wr_req_mdata = bus_a.wr_req_mdata;

  cci_mpf_test_multibeat_responder dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .o_dbg_wr_state(dbg_a)
  );
  cci_mpf_test_multibeat_responder #(.PACK_WR_RSP(1), .RD_BEAT_REVERSE(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .o_dbg_wr_state(dbg_b)
  );

  // ---------------- clock / reset / capture ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.c0_rsp_valid) c0_qa.push_back('{cyc, bus_a.c0_rsp_mdata, bus_a.c0_rsp_cl_num, bus_a.c0_rsp_data, 1'b0});
    if (bus_b.c0_rsp_valid) c0_qb.push_back('{cyc, bus_b.c0_rsp_mdata, bus_b.c0_rsp_cl_num, bus_b.c0_rsp_data, 1'b0});
    if (bus_a.c1_rsp_valid) c1_qa.push_back('{cyc, bus_a.c1_rsp_mdata, bus_a.c1_rsp_cl_num, '0, bus_a.c1_rsp_format});
    if (bus_b.c1_rsp_valid) c1_qb.push_back('{cyc, bus_b.c1_rsp_mdata, bus_b.c1_rsp_cl_num, '0, bus_b.c1_rsp_format});
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.rd_req_en = 1'b0; bus_a.rd_req_addr = '0; bus_a.rd_req_len = 2'd0; bus_a.rd_req_mdata = '0;
    bus_a.wr_req_en = 1'b0; bus_a.wr_req_sop = 1'b0; bus_a.wr_req_len = 2'd0; bus_a.wr_req_mdata = '0;
  endtask

  task automatic drive_rd(input logic [AW-1:0] addr, input logic [1:0] len, input logic [MW-1:0] mdata);
    bus_a.rd_req_en = 1'b1; bus_a.rd_req_addr = addr; bus_a.rd_req_len = len; bus_a.rd_req_mdata = mdata;
  endtask

  task automatic drive_wr(input logic sop, input logic [1:0] len, input logic [MW-1:0] mdata);
    bus_a.wr_req_en = 1'b1; bus_a.wr_req_sop = sop; bus_a.wr_req_len = len; bus_a.wr_req_mdata = mdata;
  endtask

  task automatic clear_q();
    c0_qa.delete(); c0_qb.delete(); c1_qa.delete(); c1_qb.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_q();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++; if ({bus_a.c0_rsp_valid, bus_a.c1_rsp_valid, bus_a.c0_alm_full, bus_a.c1_alm_full} !== 4'b0) begin
      n_fail++; $display("FAIL reset_a_flags: got %b expected 0000", {bus_a.c0_rsp_valid, bus_a.c1_rsp_valid, bus_a.c0_alm_full, bus_a.c1_alm_full}); end
    n_checks++; if ({bus_a.err_overflow, bus_a.err_wr_proto, bus_b.err_overflow, bus_b.err_wr_proto} !== 4'b0) begin
      n_fail++; $display("FAIL reset_errs: got %b expected 0000", {bus_a.err_overflow, bus_a.err_wr_proto, bus_b.err_overflow, bus_b.err_wr_proto}); end
    n_checks++; if ({bus_b.c0_rsp_valid, bus_b.c1_rsp_valid, bus_b.c1_rsp_format} !== 3'b0) begin
      n_fail++; $display("FAIL reset_b_flags: got %b expected 000", {bus_b.c0_rsp_valid, bus_b.c1_rsp_valid, bus_b.c1_rsp_format}); end
    n_checks++; if (bus_a.c0_rsp_data !== '0 || bus_a.c0_rsp_mdata !== '0 || bus_a.c0_rsp_cl_num !== 2'd0) begin
      n_fail++; $display("FAIL reset_c0_payload: got data=%h mdata=%h expected zeros", bus_a.c0_rsp_data, bus_a.c0_rsp_mdata); end
    n_checks++; if (dbg_a !== WR_IDLE || dbg_b !== WR_IDLE) begin
      n_fail++; $display("FAIL reset_wr_state: got %0d/%0d expected 0", dbg_a, dbg_b); end
  endtask

  task automatic test_read();
    int t0;
    logic [63:0] w;
    logic [DW-1:0] exp_data;
    do_reset();
    step(); drive_rd(42'h100, 2'd3, 16'h5); t0 = cyc;
    step(); idle_inputs();
    repeat (8) step();
    n_checks++; if (c0_qa.size() !== 4) begin n_fail++; $display("FAIL rd_a_count: got %0d expected 4", c0_qa.size()); end
    n_checks++; if (c0_qb.size() !== 4) begin n_fail++; $display("FAIL rd_b_count: got %0d expected 4", c0_qb.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < c0_qa.size()) begin
        w = 64'h100 + 64'(i); exp_data = {8{w}};
        n_checks++; if (c0_qa[i].cyc !== t0 + 2 + i) begin n_fail++; $display("FAIL rd_a_cycle[%0d]: got %0d expected %0d", i, c0_qa[i].cyc, t0 + 2 + i); end
        n_checks++; if (c0_qa[i].cl_num !== 2'(i)) begin n_fail++; $display("FAIL rd_a_cl_num[%0d]: got %0d expected %0d", i, c0_qa[i].cl_num, i); end
        n_checks++; if (c0_qa[i].mdata !== 16'h5) begin n_fail++; $display("FAIL rd_a_mdata[%0d]: got %h expected 5", i, c0_qa[i].mdata); end
        n_checks++; if (c0_qa[i].data !== exp_data) begin n_fail++; $display("FAIL rd_a_data[%0d]: got word %h expected %h", i, c0_qa[i].data[63:0], w); end
      end
      if (i < c0_qb.size()) begin
        w = 64'h103 - 64'(i); exp_data = {8{w}};
        n_checks++; if (c0_qb[i].cyc !== t0 + 2 + i) begin n_fail++; $display("FAIL rd_b_cycle[%0d]: got %0d expected %0d", i, c0_qb[i].cyc, t0 + 2 + i); end
        n_checks++; if (c0_qb[i].cl_num !== 2'(3 - i)) begin n_fail++; $display("FAIL rd_b_cl_num[%0d]: got %0d expected %0d", i, c0_qb[i].cl_num, 3 - i); end
        n_checks++; if (c0_qb[i].data !== exp_data) begin n_fail++; $display("FAIL rd_b_data[%0d]: got word %h expected %h", i, c0_qb[i].data[63:0], w); end
      end
    end
    n_checks++; if (c1_qa.size() !== 0 || c1_qb.size() !== 0) begin n_fail++; $display("FAIL rd_no_c1: got %0d/%0d expected 0", c1_qa.size(), c1_qb.size()); end
  endtask

  task automatic test_addr_wrap();
    logic [63:0] w_hi;
    do_reset();
    w_hi = 64'h3FF_FFFF_FFFF;
    step(); drive_rd('1, 2'd1, 16'h77);
    step(); idle_inputs();
    repeat (6) step();
    n_checks++; if (c0_qa.size() !== 2 || c0_qb.size() !== 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d/%0d expected 2/2", c0_qa.size(), c0_qb.size()); end
    if (c0_qa.size() == 2 && c0_qb.size() == 2) begin
      n_checks++; if (c0_qa[0].data[63:0] !== w_hi) begin n_fail++; $display("FAIL wrap_a_beat0: got %h expected %h", c0_qa[0].data[63:0], w_hi); end
      n_checks++; if (c0_qa[1].data[63:0] !== 64'h0 || c0_qa[1].data[DW-1:DW-64] !== 64'h0) begin n_fail++; $display("FAIL wrap_a_beat1: got %h expected 0", c0_qa[1].data[63:0]); end
      n_checks++; if (c0_qb[0].cl_num !== 2'd1 || c0_qb[0].data[63:0] !== 64'h0) begin n_fail++; $display("FAIL wrap_b_beat0: got cl=%0d %h expected cl=1 0", c0_qb[0].cl_num, c0_qb[0].data[63:0]); end
      n_checks++; if (c0_qb[1].cl_num !== 2'd0 || c0_qb[1].data[63:0] !== w_hi) begin n_fail++; $display("FAIL wrap_b_beat1: got cl=%0d %h expected cl=0 %h", c0_qb[1].cl_num, c0_qb[1].data[63:0], w_hi); end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [MW-1:0] e_md [5];
    logic [1:0]    e_cl_a [5];
    logic [1:0]    e_cl_b [5];
    e_md   = '{16'hA, 16'hA, 16'hB, 16'hC, 16'hC};
    e_cl_a = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    e_cl_b = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    do_reset();
    step(); drive_rd(42'h0, 2'd1, 16'hA); t0 = cyc;
    step(); drive_rd(42'h0, 2'd0, 16'hB);
    step(); drive_rd(42'h0, 2'd1, 16'hC);
    step(); idle_inputs();
    repeat (8) step();
    n_checks++; if (c0_qa.size() !== 5 || c0_qb.size() !== 5) begin
      n_fail++; $display("FAIL b2b_count: got %0d/%0d expected 5/5", c0_qa.size(), c0_qb.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < c0_qa.size()) begin
        n_checks++; if (c0_qa[i].cyc !== t0 + 2 + i || c0_qa[i].mdata !== e_md[i] || c0_qa[i].cl_num !== e_cl_a[i]) begin
          n_fail++; $display("FAIL b2b_a[%0d]: got cyc=%0d md=%h cl=%0d expected cyc=%0d md=%h cl=%0d", i, c0_qa[i].cyc, c0_qa[i].mdata, c0_qa[i].cl_num, t0 + 2 + i, e_md[i], e_cl_a[i]); end
      end
      if (i < c0_qb.size()) begin
        n_checks++; if (c0_qb[i].cyc !== t0 + 2 + i || c0_qb[i].mdata !== e_md[i] || c0_qb[i].cl_num !== e_cl_b[i]) begin
          n_fail++; $display("FAIL b2b_b[%0d]: got cyc=%0d md=%h cl=%0d expected cyc=%0d md=%h cl=%0d", i, c0_qb[i].cyc, c0_qb[i].mdata, c0_qb[i].cl_num, t0 + 2 + i, e_md[i], e_cl_b[i]); end
      end
    end
  endtask

  task automatic test_write();
    int t0;
    do_reset();
    step(); drive_wr(1'b1, 2'd1, 16'h9); t0 = cyc;
    step(); drive_wr(1'b0, 2'd3, 16'hFF);
    n_checks++; if (dbg_a !== WR_OPEN) begin n_fail++; $display("FAIL wr_state_open: got %0d expected 1", dbg_a); end
    step(); idle_inputs();
    n_checks++; if (dbg_a !== WR_IDLE) begin n_fail++; $display("FAIL wr_state_closed: got %0d expected 0", dbg_a); end
    repeat (6) step();
    n_checks++; if (c1_qa.size() !== 2) begin n_fail++; $display("FAIL wr_a_count: got %0d expected 2", c1_qa.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < c1_qa.size()) begin
        n_checks++; if (c1_qa[i].cyc !== t0 + 3 + i || c1_qa[i].cl_num !== 2'(i) || c1_qa[i].fmt !== 1'b0 || c1_qa[i].mdata !== 16'h9) begin
          n_fail++; $display("FAIL wr_a[%0d]: got cyc=%0d cl=%0d fmt=%b md=%h expected cyc=%0d cl=%0d fmt=0 md=9", i, c1_qa[i].cyc, c1_qa[i].cl_num, c1_qa[i].fmt, c1_qa[i].mdata, t0 + 3 + i, i); end
      end
    end
    n_checks++; if (c1_qb.size() !== 1) begin n_fail++; $display("FAIL wr_b_count: got %0d expected 1", c1_qb.size()); end
    if (c1_qb.size() > 0) begin
      n_checks++; if (c1_qb[0].cyc !== t0 + 3 || c1_qb[0].cl_num !== 2'd1 || c1_qb[0].fmt !== 1'b1 || c1_qb[0].mdata !== 16'h9) begin
        n_fail++; $display("FAIL wr_b_packed: got cyc=%0d cl=%0d fmt=%b md=%h expected cyc=%0d cl=1 fmt=1 md=9", c1_qb[0].cyc, c1_qb[0].cl_num, c1_qb[0].fmt, c1_qb[0].mdata, t0 + 3); end
    end
    n_checks++; if (c0_qa.size() !== 0) begin n_fail++; $display("FAIL wr_no_c0: got %0d expected 0", c0_qa.size()); end
  endtask

  task automatic test_write_len0();
    int t0;
    do_reset();
    step(); drive_wr(1'b1, 2'd0, 16'h3); t0 = cyc;
    step(); idle_inputs();
    repeat (5) step();
    n_checks++; if (c1_qa.size() !== 1 || c1_qb.size() !== 1) begin
      n_fail++; $display("FAIL wr0_count: got %0d/%0d expected 1/1", c1_qa.size(), c1_qb.size()); end
    if (c1_qa.size() == 1 && c1_qb.size() == 1) begin
      n_checks++; if (c1_qa[0].cyc !== t0 + 2 || c1_qa[0].cl_num !== 2'd0 || c1_qa[0].fmt !== 1'b0 || c1_qa[0].mdata !== 16'h3) begin
        n_fail++; $display("FAIL wr0_a: got cyc=%0d cl=%0d fmt=%b md=%h expected cyc=%0d cl=0 fmt=0 md=3", c1_qa[0].cyc, c1_qa[0].cl_num, c1_qa[0].fmt, c1_qa[0].mdata, t0 + 2); end
      n_checks++; if (c1_qb[0].cyc !== t0 + 2 || c1_qb[0].cl_num !== 2'd0 || c1_qb[0].fmt !== 1'b1) begin
        n_fail++; $display("FAIL wr0_b: got cyc=%0d cl=%0d fmt=%b expected cyc=%0d cl=0 fmt=1", c1_qb[0].cyc, c1_qb[0].cl_num, c1_qb[0].fmt, t0 + 2); end
    end
  endtask

  task automatic test_wr_proto();
    do_reset();
    step(); drive_wr(1'b1, 2'd3, 16'h1);
    step(); drive_wr(1'b0, 2'd0, 16'h0);
    step(); drive_wr(1'b1, 2'd0, 16'h2);
    step(); idle_inputs();
    repeat (6) step();
    n_checks++; if (bus_a.err_wr_proto !== 1'b1 || bus_b.err_wr_proto !== 1'b1) begin
      n_fail++; $display("FAIL proto_sop_err: got %b/%b expected 1/1", bus_a.err_wr_proto, bus_b.err_wr_proto); end
    n_checks++; if (bus_a.err_overflow !== 1'b0) begin n_fail++; $display("FAIL proto_no_ovf: got %b expected 0", bus_a.err_overflow); end
    n_checks++; if (c1_qa.size() !== 1 || c1_qb.size() !== 1) begin
      n_fail++; $display("FAIL proto_count: got %0d/%0d expected 1/1", c1_qa.size(), c1_qb.size()); end
    if (c1_qa.size() == 1) begin
      n_checks++; if (c1_qa[0].mdata !== 16'h2 || c1_qa[0].cl_num !== 2'd0) begin
        n_fail++; $display("FAIL proto_rsp: got md=%h cl=%0d expected md=2 cl=0", c1_qa[0].mdata, c1_qa[0].cl_num); end
    end
    // Orphan non-sop flit after a clean reset.
    do_reset();
    step(); drive_wr(1'b0, 2'd0, 16'h6);
    step(); idle_inputs();
    repeat (5) step();
    n_checks++; if (bus_a.err_wr_proto !== 1'b1 || bus_b.err_wr_proto !== 1'b1) begin
      n_fail++; $display("FAIL orphan_err: got %b/%b expected 1/1", bus_a.err_wr_proto, bus_b.err_wr_proto); end
    n_checks++; if (c1_qa.size() !== 0 || dbg_a !== WR_IDLE) begin
      n_fail++; $display("FAIL orphan_ignored: got rsp=%0d state=%0d expected 0/0", c1_qa.size(), dbg_a); end
  endtask

  task automatic test_overflow();
    int k;
    do_reset();
    // len-3 requests every cycle: one pop per 4 cycles, so occupancy fills.
    for (int i = 0; i <= 20; i++) begin
      step();
      drive_rd(42'h0, 2'd3, MW'(i));
      if (i == 14) begin
        n_checks++; if (bus_a.c0_alm_full !== 1'b0 || bus_b.c0_alm_full !== 1'b0) begin
          n_fail++; $display("FAIL ovf_alm_at_11: got %b/%b expected 0/0", bus_a.c0_alm_full, bus_b.c0_alm_full); end
      end
      if (i == 15) begin
        n_checks++; if (bus_a.c0_alm_full !== 1'b1 || bus_b.c0_alm_full !== 1'b1) begin
          n_fail++; $display("FAIL ovf_alm_at_12: got %b/%b expected 1/1", bus_a.c0_alm_full, bus_b.c0_alm_full); end
      end
      if (i == 20) begin
        n_checks++; if (bus_a.err_overflow !== 1'b0) begin
          n_fail++; $display("FAIL ovf_early: got %b expected 0", bus_a.err_overflow); end
      end
    end
    step(); idle_inputs();
    n_checks++; if (bus_a.err_overflow !== 1'b1 || bus_b.err_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b/%b expected 1/1", bus_a.err_overflow, bus_b.err_overflow); end
    for (int i = 0; i < 20; i++) repeat (4) exp_q.push_back(MW'(i));
    repeat (90) step();
    n_checks++; if (c0_qa.size() !== 80 || c0_qb.size() !== 80) begin
      n_fail++; $display("FAIL ovf_count: got %0d/%0d expected 80/80", c0_qa.size(), c0_qb.size()); end
    k = 0;
    while (exp_q.size() > 0 && k < c0_qa.size() && k < c0_qb.size()) begin
      n_checks++; if (c0_qa[k].mdata !== exp_q[0] || c0_qa[k].cl_num !== 2'(k % 4) || c0_qb[k].cl_num !== 2'(3 - k % 4)) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got md=%h cl=%0d/%0d expected md=%h cl=%0d/%0d", k, c0_qa[k].mdata, c0_qa[k].cl_num, c0_qb[k].cl_num, exp_q[0], k % 4, 3 - k % 4); end
      void'(exp_q.pop_front());
      k++;
    end
    n_checks++; if (bus_a.c0_alm_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_alm: got %b expected 0", bus_a.c0_alm_full); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    step(); drive_rd(42'h40, 2'd3, 16'h44); drive_wr(1'b0, 2'd0, 16'h0);
    step(); idle_inputs();
    step();
    n_checks++; if (bus_a.err_wr_proto !== 1'b1 || bus_a.c0_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got err=%b valid=%b expected 1/1", bus_a.err_wr_proto, bus_a.c0_rsp_valid); end
    step(); reset = 1'b1;
    step();
    n_checks++; if (bus_a.c0_rsp_valid !== 1'b0 || bus_b.c0_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b/%b expected 0/0", bus_a.c0_rsp_valid, bus_b.c0_rsp_valid); end
    n_checks++; if (bus_a.err_wr_proto !== 1'b0 || bus_b.err_wr_proto !== 1'b0) begin
      n_fail++; $display("FAIL midrst_err: got %b/%b expected 0/0", bus_a.err_wr_proto, bus_b.err_wr_proto); end
    step(); reset = 1'b0;
    repeat (8) step();
    n_checks++; if (c0_qa.size() !== 2 || c0_qb.size() !== 2) begin
      n_fail++; $display("FAIL midrst_beats: got %0d/%0d expected 2/2", c0_qa.size(), c0_qb.size()); end
    n_checks++; if (bus_a.err_overflow !== 1'b0 || bus_a.err_wr_proto !== 1'b0 || c1_qa.size() !== 0) begin
      n_fail++; $display("FAIL midrst_quiet: got ovf=%b proto=%b c1=%0d expected 0/0/0", bus_a.err_overflow, bus_a.err_wr_proto, c1_qa.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_read();
    test_addr_wrap();
    test_back_to_back();
    test_write();
    test_write_len0();
    test_wr_proto();
    test_overflow();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
